// File: rtl/spi_mem_burst_pkg.sv
// spi_pkg: shared definitions for the spi_mem_burst SPI memory master.
//   - 23LC/25-series command opcodes
//   - transaction state encoding
// SPI_FAST_READ_EN (when defined) makes reads use SPI_CMD_FAST_READ with a
// DUMMY byte; the encoding below is the same either way.
package spi_pkg;

    localparam logic [7:0] SPI_CMD_READ      = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE     = 8'h02;
    localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        WDATA,
        RDATA,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_mem_burst_clk_gen.sv
// spi_clk_gen: SPI mode-0 clock generator.
//   clk, rst     system clock, async active-high reset
//   enable       run SCLK; when low, SCLK is parked low and the divider cleared
//   sclk         SPI clock, half-period CLK_DIV clk cycles, idles low
//   rise_tick    high in the clk cycle whose closing edge drives sclk high
//   fall_tick    high in the clk cycle whose closing edge drives sclk low
// The ticks announce the edge one cycle early so the master can move mosi
// and sample miso on the very clk edge that moves sclk.
module spi_clk_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick      = enable && (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = tick && !sclk;
    assign fall_tick = tick && sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= !sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_mem_burst.sv
// spi_mem_burst: SPI master for serial SRAM/flash, single and burst access.
//   clk, rst          system clock, async active-high reset
//   start             request (taken in IDLE only, not in the done cycle)
//   write/cs_sel/address/len   transaction attributes, latched at start
//   wdata, wready     write byte stream; wdata taken in the wready cycle
//   rdata, rvalid     read byte stream; rvalid pulses when rdata updates
//   busy, done        transaction in flight / one-cycle completion pulse
//   sclk, cs_n, mosi, miso     SPI mode-0 bus, MSB first
// Define SPI_FAST_READ_EN to issue 0x0B reads with 8 dummy clocks.
module spi_mem_burst
    import spi_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int CLK_DIV   = 1,
    parameter int NUM_CS    = 2,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = $clog2(MAX_BURST + 1),
    parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              write,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [ADDR_W-1:0] address,
    input  logic [LEN_W-1:0]  len,
    input  logic [7:0]        wdata,
    output logic              wready,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int TX_W  = 8 + ADDR_W;
    localparam int BIT_W = $clog2(ADDR_W);
    localparam int GAP_W = $clog2(CLK_DIV + 1);

    spi_state_t        state, state_nxt;
    logic              write_q;
    logic [CS_W-1:0]   cs_q;
    logic [LEN_W-1:0]  len_q, len_eff, byte_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TX_W-1:0]   tx;      // command+address, later the current write byte in the top 8 bits
    logic [6:0]        rx;
    logic [7:0]        cmd;
    logic              active, accept, last_byte, phase_end;
    logic              rise_tick, fall_tick;

`ifdef SPI_FAST_READ_EN
    assign cmd = write ? SPI_CMD_WRITE : SPI_CMD_FAST_READ;
`else
    assign cmd = write ? SPI_CMD_WRITE : SPI_CMD_READ;
`endif

    assign active    = state inside {CMD, ADDR, DUMMY, WDATA, RDATA};
    assign accept    = (state == IDLE) && start && !done;
    assign last_byte = byte_cnt == len_q - LEN_W'(1);
    // A phase ends on the falling edge that closes its last bit.
    assign phase_end = fall_tick &&
                       (bit_cnt == ((state == ADDR) ? BIT_W'(ADDR_W - 1) : BIT_W'(7)));
    assign busy      = state != IDLE;
    assign mosi      = (state inside {CMD, ADDR, WDATA}) && tx[TX_W-1];
    // Next byte's bit 7 goes onto mosi at the edge ending this cycle.
    assign wready    = phase_end && ((state == ADDR && write_q) ||
                                     (state == WDATA && !last_byte));

    always_comb begin
        len_eff = len;
        if (len == '0)
            len_eff = LEN_W'(1);
        else if (32'(len) > MAX_BURST)
            len_eff = LEN_W'(MAX_BURST);
    end

    always_comb begin
        for (int i = 0; i < NUM_CS; i++)
            cs_n[i] = !(active && (32'(cs_q) == i));
    end

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .enable    (active),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = CMD;
            CMD:   if (phase_end) state_nxt = ADDR;
            ADDR: begin
                if (phase_end) begin
                    if (write_q)
                        state_nxt = WDATA;
                    else
`ifdef SPI_FAST_READ_EN
                        state_nxt = DUMMY;
`else
                        state_nxt = RDATA;
`endif
                end
            end
`ifdef SPI_FAST_READ_EN
            DUMMY: if (phase_end) state_nxt = RDATA;
`endif
            WDATA, RDATA: if (phase_end && last_byte) state_nxt = GAP;
            GAP:   if (gap_cnt == GAP_W'(CLK_DIV - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q  <= 1'b0;
            cs_q     <= '0;
            len_q    <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            tx       <= '0;
            rx       <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done   <= 1'b0;
            rvalid <= 1'b0;
            if (accept) begin
                write_q  <= write;
                cs_q     <= (32'(cs_sel) >= NUM_CS) ? '0 : cs_sel;
                len_q    <= len_eff;
                tx       <= {cmd, address};
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
                if (state_nxt == IDLE) done <= 1'b1;
            end
            if (rise_tick) begin
                rx <= {rx[5:0], miso};
                if (state == RDATA && bit_cnt == BIT_W'(7)) begin
                    rdata  <= {rx, miso};
                    rvalid <= 1'b1;
                end
            end
            if (fall_tick) begin
                tx      <= tx << 1;
                bit_cnt <= bit_cnt + 1'b1;
                if (phase_end) begin
                    bit_cnt <= '0;
                    gap_cnt <= '0;
                    if (state inside {WDATA, RDATA}) byte_cnt <= byte_cnt + 1'b1;
                    if (wready) tx[TX_W-1 -: 8] <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_burst.sv
// tb_spi_mem_burst: directed bench for spi_mem_burst.
// Two DUTs (CLK_DIV=1 and CLK_DIV=3) share the request inputs; each has its
// own start, a SPI slave model answering reads with resp(i), and a bus
// monitor that records the mosi stream, SCLK run lengths and CS activity.
module tb_spi_mem_burst;

    localparam int AW = 16, MB = 16, NCS = 2;
    localparam int DIV0 = 1, DIV1 = 3;
`ifdef SPI_FAST_READ_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        int         g;
        bit         wr;
        int         sel;
        logic [15:0] addr;
        int         len;
        int         exp_len;
        logic [1:0] exp_mask;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]     start_v = '0;
    logic           write = 1'b0;
    logic [0:0]     cs_sel = '0;
    logic [AW-1:0]  address = '0;
    logic [4:0]     len = '0;
    logic [7:0]     wdata_a [2];
    logic [7:0]     rdata_a [2];
    logic [NCS-1:0] cs_n_a  [2];
    logic [1:0]     wready_a, rvalid_a, busy_a, done_a, sclk_a, mosi_a, miso_a;

    int             cs_low_a [2], rises_a [2], bad_a [2], rv_a [2], wr_a [2], rderr_a [2], txn_a [2];
    logic [NCS-1:0] seen_a [2];
    logic [255:0]   mb_a [2];

    int n_assert = 0, n_fail = 0;

    function automatic logic [7:0] resp(int i);
        return 8'hA5 + 8'(i * 17);
    endfunction

    function automatic logic miso_bit(int k);
        int pre, d;
        logic [7:0] b;
        pre = 8 + AW + (FAST ? 8 : 0);
        if (k < pre) return 1'b0;
        d = k - pre;
        b = resp(d / 8);
        return b[7 - (d % 8)];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DIV = (g == 0) ? DIV0 : DIV1;
        int cs_low = 0, rises = 0, run = 0, bad = 0, rv = 0, wr = 0, rderr = 0, txn = 0, widx = 0;
        logic prev_act = 1'b0, prev_sclk = 1'b0;
        logic [NCS-1:0] seen = '0;
        logic [7:0] cur = '0;
        logic [255:0] mb = '0;

        spi_mem_burst #(.ADDR_W(AW), .CLK_DIV(DIV), .NUM_CS(NCS), .MAX_BURST(MB)) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g]), .write(write), .cs_sel(cs_sel),
            .address(address), .len(len), .wdata(wdata_a[g]), .wready(wready_a[g]),
            .rdata(rdata_a[g]), .rvalid(rvalid_a[g]), .busy(busy_a[g]), .done(done_a[g]),
            .sclk(sclk_a[g]), .cs_n(cs_n_a[g]), .mosi(mosi_a[g]), .miso(miso_a[g]));

        assign miso_a[g]   = miso_bit(rises);
        assign wdata_a[g]  = 8'(17 * (widx + 1));
        assign cs_low_a[g] = cs_low;
        assign rises_a[g]  = rises;
        assign bad_a[g]    = bad;
        assign rv_a[g]     = rv;
        assign wr_a[g]     = wr;
        assign rderr_a[g]  = rderr;
        assign txn_a[g]    = txn;
        assign seen_a[g]   = seen;
        assign mb_a[g]     = mb;

        // Write-byte source advances after each consumed byte.
        always @(posedge clk) begin
            if (!busy_a[g])       widx <= 0;
            else if (wready_a[g]) widx <= widx + 1;
        end

        always @(negedge clk) begin
            if (cs_n_a[g] != '1) begin
                if (!prev_act) begin
                    cs_low <= 1; seen <= ~cs_n_a[g]; run <= 1; bad <= 0;
                    rises <= 0; rv <= 0; wr <= 0; rderr <= 0; txn <= txn + 1;
                end else begin
                    cs_low <= cs_low + 1;
                    seen   <= seen | ~cs_n_a[g];
                    if (sclk_a[g] != prev_sclk) begin
                        run <= 1;
                        if (run != DIV) bad <= bad + 1;
                        if (sclk_a[g]) begin
                            rises <= rises + 1;
                            cur   <= {cur[6:0], mosi_a[g]};
                            if (rises % 8 == 7) mb[8*(rises/8) +: 8] <= {cur[6:0], mosi_a[g]};
                        end
                    end else begin
                        run <= run + 1;
                    end
                    if (rvalid_a[g]) begin
                        rv <= rv + 1;
                        if (rdata_a[g] !== resp(rv)) rderr <= rderr + 1;
                    end
                    if (wready_a[g]) wr <= wr + 1;
                end
            end else if (prev_act && run != DIV) begin
                bad <= bad + 1;
            end
            prev_act  <= (cs_n_a[g] != '1);
            prev_sclk <= sclk_a[g];
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int g, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done_a[g]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        write = v.wr; cs_sel = 1'(v.sel); address = v.addr; len = 5'(v.len);
        start_v[v.g] = 1'b1;
        @(negedge clk);
        start_v[v.g] = 1'b0;
    endtask

    task automatic finish_check(input vec_t v, input string tag);
        bit ok;
        int p, div, nbad, first;
        logic [7:0] e, a;
        wait_done(v.g, ok);
        check({tag, "_done"}, ok, 1);
        if (!ok) return;
        check({tag, "_busy_at_done"}, busy_a[v.g], 0);
        div = (v.g == 0) ? DIV0 : DIV1;
        p = 8 + AW + ((FAST && !v.wr) ? 8 : 0) + 8 * v.exp_len;
        check({tag, "_cs_low_cycles"}, cs_low_a[v.g], 2 * div * p);
        check({tag, "_sclk_rises"}, rises_a[v.g], p);
        check({tag, "_sclk_runs_bad"}, bad_a[v.g], 0);
        check({tag, "_cs_mask"}, seen_a[v.g], v.exp_mask);
        check({tag, "_rvalid_cnt"}, rv_a[v.g], v.wr ? 0 : v.exp_len);
        check({tag, "_wready_cnt"}, wr_a[v.g], v.wr ? v.exp_len : 0);
        check({tag, "_rdata_err"}, rderr_a[v.g], 0);
        nbad = 0; first = -1;
        for (int i = 0; i < p / 8; i++) begin
            if (i == 0)      e = v.wr ? 8'h02 : (FAST ? 8'h0B : 8'h03);
            else if (i == 1) e = v.addr[15:8];
            else if (i == 2) e = v.addr[7:0];
            else             e = v.wr ? 8'(17 * (i - 2)) : 8'h00;
            a = mb_a[v.g][8*i +: 8];
            if (a !== e) begin nbad++; if (first < 0) first = i; end
        end
        check({tag, "_mosi_bad_bytes"}, nbad, 0);
        if (nbad != 0) $display("  first bad mosi byte index %0d", first);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done_a[v.g], 0);
    endtask

    initial begin
        vec_t vecs [6];
        vec_t v;
        bit   ok;
        int   t0;

        vecs[0] = '{0, 1'b0, 0, 16'h1234, 1,  1,  2'b01};
        vecs[1] = '{0, 1'b1, 0, 16'h5678, 4,  4,  2'b01};
        vecs[2] = '{1, 1'b0, 1, 16'h00FF, 2,  2,  2'b10};
        vecs[3] = '{0, 1'b0, 0, 16'hABCD, 0,  1,  2'b01};
        vecs[4] = '{0, 1'b1, 1, 16'h0001, 21, 16, 2'b10};
        vecs[5] = '{1, 1'b1, 0, 16'hFEDC, 3,  3,  2'b01};

        #12;
        for (int g = 0; g < 2; g++) begin
            check("rst_sclk",   sclk_a[g], 0);
            check("rst_cs_n",   cs_n_a[g], 2'b11);
            check("rst_mosi",   mosi_a[g], 0);
            check("rst_busy",   busy_a[g], 0);
            check("rst_done",   done_a[g], 0);
            check("rst_wready", wready_a[g], 0);
            check("rst_rvalid", rvalid_a[g], 0);
            check("rst_rdata",  rdata_a[g], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i]);
            finish_check(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of the address phase.
        issue(vecs[0]);
        @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rises_a[0] >= 12) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("midrst_reached_addr", ok, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs_n", cs_n_a[0], 2'b11);
        check("midrst_sclk", sclk_a[0], 0);
        check("midrst_busy", busy_a[0], 0);
        check("midrst_mosi", mosi_a[0], 0);
        @(negedge clk);
        rst = 1'b0;
        issue(vecs[0]);
        finish_check(vecs[0], "post_rst");

        // start held high across a whole transaction.
        v = vecs[0];
        t0 = txn_a[0];
        @(negedge clk);
        write = v.wr; cs_sel = 1'(v.sel); address = v.addr; len = 5'(v.len);
        start_v[0] = 1'b1;
        wait_done(0, ok);
        check("held_done", ok, 1);
        check("held_one_txn", txn_a[0] - t0, 1);
        check("held_rvalid_cnt", rv_a[0], 1);
        @(negedge clk);
        check("held_ignored_in_done_cycle", busy_a[0], 0);
        @(negedge clk);
        check("held_restart", busy_a[0], 1);
        start_v[0] = 1'b0;
        finish_check(v, "held_second");
        check("held_two_txn", txn_a[0] - t0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
